// File: rtl/alu_ctrl_pkg.sv
// Shared types, field positions and helpers for the ALU/register-file controller.
package alu_ctrl_pkg;

    localparam int INSTR_W = 20;
    localparam int DATA_W  = 8;
    localparam int REG_W   = 9;

    // Instruction field bit positions
    localparam int IMM_SEL = 19;
    localparam int ZERO_A  = 18;
    localparam int OP_HI   = 17;
    localparam int OP_LO   = 15;
    localparam int RD_HI   = 14;
    localparam int RS_HI   = 12;
    localparam int RT_HI   = 10;
    localparam int IMM_HI  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    // Widen an ALU result to the register width by replicating its sign bit.
    function automatic logic [REG_W-1:0] sign_ext(input logic [DATA_W-1:0] v);
        return {v[DATA_W-1], v};
    endfunction

endpackage

// File: rtl/alu_instr_decode.sv
// Splits an instruction word into its individual control fields.
module alu_instr_decode
    import alu_ctrl_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic               imm_sel,
    output logic               zero_a,
    output logic [2:0]         alu_op,
    output logic [1:0]         rd,
    output logic [1:0]         rs,
    output logic [1:0]         rt,
    output logic [8:0]         imm9
);

    assign imm_sel = instr[IMM_SEL];
    assign zero_a  = instr[ZERO_A];
    assign alu_op  = instr[OP_HI:OP_LO];
    assign rd      = instr[RD_HI -: 2];
    assign rs      = instr[RS_HI -: 2];
    assign rt      = instr[RT_HI -: 2];
    assign imm9    = instr[IMM_HI:0];

endmodule

// File: rtl/alu_regfile_ctrl.sv
// Four-cycle sequencer (IDLE/READ/EXEC/WB) driving the ALU/register-file control side.
// Control fields come from a latched copy of the accepted instruction, so nothing
// downstream sees instr or instr_valid combinationally.
module alu_regfile_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter bit TRAP_ON_OVF = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [1:0]         rd0_addr,
    output logic [1:0]         rd1_addr,
    output logic [1:0]         wr_addr,
    output logic               reg_read,
    output logic               reg_write,
    output logic [REG_W-1:0]   wr_data,
    output logic [8:0]         imm,
    output logic               alu_src0,
    output logic               alu_src1,
    output logic [2:0]         alu_op,
    input  logic [DATA_W-1:0]  result,
    input  logic               ovf,
    input  logic               zero,
    output logic               done,
    output logic [DATA_W-1:0]  done_result,
    output logic               done_ovf,
    output logic               done_zero,
    output logic               err
);

    state_t               state_r;
    state_t               state_nxt_s;
    logic [INSTR_W-1:0]   instr_r;
    logic                 ready_r;
    logic                 reg_read_r;
    logic                 reg_write_r;
    logic                 done_r;
    logic                 err_r;
    logic [REG_W-1:0]     wr_data_r;
    logic [DATA_W-1:0]    done_result_r;
    logic                 done_ovf_r;
    logic                 done_zero_r;
    logic                 accept_s;
    logic                 trap_s;
    logic                 exec_s;

    assign accept_s = (state_r == IDLE) && instr_valid && ready_r;
    assign exec_s   = (state_r == EXEC);
    assign trap_s   = TRAP_ON_OVF && ovf;

    // State register; reset overrides any transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: only IDLE waits on the handshake, the rest step unconditionally.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = READ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ:    state_nxt_s = EXEC;
            EXEC:    state_nxt_s = WB;
            WB:      state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Instruction latch, loaded only on a successful handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_r <= {INSTR_W{1'b0}};
        end else if (accept_s) begin
            instr_r <= instr;
        end else begin
            instr_r <= instr_r;
        end
    end

    // Registered handshake and phase strobes, computed from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r     <= 1'b1;
            reg_read_r  <= 1'b0;
            reg_write_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            ready_r     <= (state_nxt_s == IDLE);
            reg_read_r  <= (state_nxt_s == READ) || (state_nxt_s == EXEC);
            reg_write_r <= exec_s && !trap_s;
            done_r      <= exec_s;
        end
    end

    // Capture ALU result and flags at the end of EXEC; held until the next capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_data_r     <= {REG_W{1'b0}};
            done_result_r <= {DATA_W{1'b0}};
            done_ovf_r    <= 1'b0;
            done_zero_r   <= 1'b0;
        end else if (exec_s) begin
            wr_data_r     <= sign_ext(result);
            done_result_r <= result;
            done_ovf_r    <= ovf;
            done_zero_r   <= zero;
        end else begin
            wr_data_r     <= wr_data_r;
            done_result_r <= done_result_r;
            done_ovf_r    <= done_ovf_r;
            done_zero_r   <= done_zero_r;
        end
    end

    // Sticky overflow trap, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r || (exec_s && trap_s);
        end
    end

    alu_instr_decode u_decode (
        .instr   (instr_r),
        .imm_sel (alu_src1),
        .zero_a  (alu_src0),
        .alu_op  (alu_op),
        .rd      (wr_addr),
        .rs      (rd0_addr),
        .rt      (rd1_addr),
        .imm9    (imm)
    );

    assign instr_ready = ready_r;
    assign reg_read    = reg_read_r;
    assign reg_write   = reg_write_r;
    assign wr_data     = wr_data_r;
    assign done        = done_r;
    assign done_result = done_result_r;
    assign done_ovf    = done_ovf_r;
    assign done_zero   = done_zero_r;
    assign err         = err_r;

endmodule

// File: tb/tb_alu_regfile_ctrl.sv
// Directed bench for alu_regfile_ctrl: one instance without trap (a) and one with trap (b)
// share the stimulus; completions are checked against a scoreboard queue.
module tb_alu_regfile_ctrl;

    typedef struct {
        logic [8:0] wr_data;
        logic [7:0] res;
        logic       ov;
        logic       zr;
        logic [1:0] wa;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] instr;
    logic        instr_valid;
    logic [7:0]  result;
    logic        ovf;
    logic        zero;

    logic       ready_a, rr_a, rw_a, src0_a, src1_a, done_a, dovf_a, dzero_a, err_a;
    logic [1:0] ra0_a, ra1_a, wa_a;
    logic [8:0] wd_a, imm_a;
    logic [2:0] op_a;
    logic [7:0] dres_a;

    logic       ready_b, rr_b, rw_b, src0_b, src1_b, done_b, dovf_b, dzero_b, err_b;
    logic [1:0] ra0_b, ra1_b, wa_b;
    logic [8:0] wd_b, imm_b;
    logic [2:0] op_b;
    logic [7:0] dres_b;

    int   n_cmp = 0;
    int   n_err = 0;
    logic err_b_exp = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_regfile_ctrl #(.TRAP_ON_OVF(1'b0)) dut_a (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(ready_a), .rd0_addr(ra0_a), .rd1_addr(ra1_a), .wr_addr(wa_a),
        .reg_read(rr_a), .reg_write(rw_a), .wr_data(wd_a), .imm(imm_a),
        .alu_src0(src0_a), .alu_src1(src1_a), .alu_op(op_a),
        .result(result), .ovf(ovf), .zero(zero),
        .done(done_a), .done_result(dres_a), .done_ovf(dovf_a), .done_zero(dzero_a),
        .err(err_a)
    );

    alu_regfile_ctrl #(.TRAP_ON_OVF(1'b1)) dut_b (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(ready_b), .rd0_addr(ra0_b), .rd1_addr(ra1_b), .wr_addr(wa_b),
        .reg_read(rr_b), .reg_write(rw_b), .wr_data(wd_b), .imm(imm_b),
        .alu_src0(src0_b), .alu_src1(src1_b), .alu_op(op_b),
        .result(result), .ovf(ovf), .zero(zero),
        .done(done_b), .done_result(dres_b), .done_ovf(dovf_b), .done_zero(dzero_b),
        .err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [19:0] ins, input logic [7:0] res,
                                input logic ov, input logic zr);
        exp_t e;
        e.wr_data = {res[7], res};
        e.res     = res;
        e.ov      = ov;
        e.zr      = zr;
        e.wa      = ins[14:13];
        return e;
    endfunction

    // Scoreboard: every completion pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && done_a === 1'b1) begin
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL sb_unexpected_done: observed done=1 expected none pending");
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_wr_data",     wd_a,   e.wr_data);
                chk("sb_wr_data_b",   wd_b,   e.wr_data);
                chk("sb_done_result", dres_a, e.res);
                chk("sb_done_ovf",    dovf_a, e.ov);
                chk("sb_done_zero",   dzero_a, e.zr);
                chk("sb_wr_addr",     wa_a,   e.wa);
                chk("sb_reg_write_a", rw_a,   1'b1);
                chk("sb_reg_write_b", rw_b,   !e.ov);
                chk("sb_done_b",      done_b, 1'b1);
                chk("sb_done_ovf_b",  dovf_b, e.ov);
            end
        end
    end

    // Offer one instruction, then check every cycle of its READ/EXEC/WB sequence.
    task automatic issue(input logic [19:0] ins, input logic [7:0] res,
                         input logic ov, input logic zr);
        int guard;
        guard = 0;
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        while (ready_a !== 1'b1 && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait", ready_a, 1'b1);
        sb.push_back(mk(ins, res, ov, zr));
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        result      = res;
        ovf         = ov;
        zero        = zr;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 3 && ov) err_b_exp = 1'b1;
            chk("fields", {ready_a, src1_a, src0_a, op_a, wa_a, ra0_a, ra1_a, imm_a},
                {1'b0, ins[19], ins[18], ins[17:15], ins[14:13], ins[12:11], ins[10:9], ins[8:0]});
            chk("reg_read",    rr_a,   (c < 3));
            chk("reg_write_a", rw_a,   (c == 3));
            chk("reg_write_b", rw_b,   (c == 3) && !ov);
            chk("done",        done_a, (c == 3));
            chk("err_a",       err_a,  1'b0);
            chk("err_b",       err_b,  err_b_exp);
            if (c == 3) chk("wr_data", wd_a, {res[7], res});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] a_ins;
        logic [19:0] b_ins;
        rst         = 1'b1;
        instr       = 20'h00000;
        instr_valid = 1'b0;
        result      = 8'h00;
        ovf         = 1'b0;
        zero        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready",     ready_a, 1'b1);
        chk("rst_outs",      {rr_a, rw_a, done_a, err_a, src0_a, src1_a},  6'b000000);
        chk("rst_addr",      {ra0_a, ra1_a, wa_a, op_a, imm_a, wd_a}, 27'd0);
        chk("rst_done_res",  {dres_a, dovf_a, dzero_a}, 10'd0);

        // Immediate load: zero_a=1, imm_sel=1, rd=1, imm=5
        issue(20'hC2005, 8'h05, 1'b0, 1'b0);
        chk("imm_load_imm", imm_a, 9'h005);
        chk("imm_load_wa",  wa_a,  2'd1);

        // Sign extension of a negative result
        issue(20'h8A0F0, 8'hF0, 1'b0, 1'b0);
        @(negedge clk);
        chk("sext_hold_res",  dres_a, 8'hF0);
        chk("sext_hold_wd",   wd_a,   9'h1F0);
        chk("sext_done_low",  done_a, 1'b0);

        // Overflow: trapping instance withholds the write and sets err
        issue(20'h94A7F, 8'h80, 1'b1, 1'b0);
        @(negedge clk);
        chk("ovf_err_sticky", err_b, 1'b1);
        chk("ovf_done_ovf",   dovf_b, 1'b1);

        // Register-register: rs=2, rt=3, rd=2, op=2; err_b must remain set
        issue(20'h15600, 8'h07, 1'b0, 1'b0);
        chk("rr_addrs", {ra0_a, ra1_a, wa_a, src0_a, src1_a}, {2'd2, 2'd3, 2'd2, 1'b0, 1'b0});

        // Back-to-back with instr_valid held high
        a_ins = 20'h8EDFF;
        b_ins = 20'h21A00;
        @(negedge clk);
        instr       = a_ins;
        instr_valid = 1'b1;
        chk("b2b_ready0", ready_a, 1'b1);
        sb.push_back(mk(a_ins, 8'h80, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        result = 8'h80;
        ovf    = 1'b0;
        zero   = 1'b0;
        instr  = b_ins;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("b2b_ready", ready_a, (c == 4));
            chk("b2b_first_addr", {wa_a, ra0_a, ra1_a}, {a_ins[14:13], a_ins[12:11], a_ins[10:9]});
        end
        sb.push_back(mk(b_ins, 8'h00, 1'b0, 1'b1));
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        result      = 8'h00;
        zero        = 1'b1;
        @(negedge clk);
        chk("b2b_second_addr", {wa_a, ra0_a, ra1_a, op_a}, {b_ins[14:13], b_ins[12:11], b_ins[10:9], b_ins[17:15]});
        chk("b2b_ready_busy", ready_a, 1'b0);
        repeat (2) @(negedge clk);
        chk("b2b_second_done", done_a, 1'b1);

        // Reset asserted mid-EXEC discards the in-flight instruction
        @(negedge clk);
        instr       = 20'hC3033;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        result      = 8'h33;
        ovf         = 1'b1;
        zero        = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_exec_reached", rr_a, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        err_b_exp = 1'b0;
        @(negedge clk);
        chk("rst2_ready",     ready_a, 1'b1);
        chk("rst2_reg_write", {rw_a, rw_b}, 2'b00);
        chk("rst2_done",      {done_a, done_b}, 2'b00);
        chk("rst2_err_b",     err_b, err_b_exp);
        chk("rst2_latch",     {wa_a, ra0_a, imm_a, dres_a}, 21'd0);
        repeat (4) @(negedge clk);
        chk("rst2_no_write",  {rw_a, rw_b, done_a}, 3'b000);
        chk("sb_drained",     sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
